// File: rtl/db_req_queue.sv
// db_req_queue: request buffer between the Ethernet parser and the KVS lookup
// core. It queues {key, flag} requests, issues them to the core with a bounded
// number outstanding and forwards in-order results back to the parser.
// Optional feature macro: DB_REQ_QUEUE_TIMEOUT_EN adds a watchdog timer that
// retires a stalled request with a synthetic TIMEOUT_FLAG result.
module db_req_queue #(
  parameter int                  KEY_SIZE     = 96,
  parameter int                  FLAG_SIZE    = 4,
  parameter int                  DEPTH_LOG2   = 4,
  parameter int                  MAX_INFLIGHT = 4,
  parameter int                  TIMEOUT_CYC  = 1024,
  parameter logic [FLAG_SIZE-1:0] TIMEOUT_FLAG = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_SIZE-1:0]   in_key,
  input  logic [FLAG_SIZE-1:0]  in_flag,
  input  logic                  in_valid,
  output logic                  out_valid,
  output logic [FLAG_SIZE-1:0]  out_flag,
  output logic [KEY_SIZE-1:0]   db_key,
  output logic [FLAG_SIZE-1:0]  db_flag,
  output logic                  db_valid,
  input  logic                  db_out_valid,
  input  logic [FLAG_SIZE-1:0]  db_out_flag,
  output logic [DEPTH_LOG2:0]   level,
  output logic [31:0]           drop_cnt,
  output logic                  spurious
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IFW   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [IFW-1:0]      INF_MAX  = IFW'(MAX_INFLIGHT);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  logic [KEY_SIZE+FLAG_SIZE-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]         wr_ptr;
  logic [DEPTH_LOG2-1:0]         rd_ptr;
  state_t                        state;
  logic [IFW-1:0]                inflight;

  logic wr_en;
  logic pop;
  logic rsp_ok;
  logic timeout_fire;
  logic inc;
  logic dec;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Decode this cycle's push/pop and in-flight accounting events
  always_comb begin
    wr_en  = in_valid && (level != LVL_FULL);
    pop    = (state == S_IDLE) && (level != '0) && (inflight < INF_MAX);
    rsp_ok = db_out_valid && (inflight != '0);
    inc    = (state == S_ISSUE);
    dec    = rsp_ok || timeout_fire;
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {in_key, in_flag};
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, pop};
      if (in_valid && !wr_en) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Issue FSM: pop into the core register, hold ISSUE one cycle, count it in flight on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      db_valid <= 1'b0;
      db_key   <= '0;
      db_flag  <= '0;
      inflight <= '0;
    end else begin
      inflight <= inflight + IFW'(inc) - IFW'(dec);
      case (state)
        S_IDLE: begin
          db_valid <= 1'b0;
          if (pop) begin
            state             <= S_ISSUE;
            db_valid          <= 1'b1;
            {db_key, db_flag} <= mem[rd_ptr];
          end
        end
        S_ISSUE: begin
          db_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          db_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Result register: a real result always takes precedence over a synthetic one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_flag  <= '0;
      spurious  <= 1'b0;
    end else begin
      out_valid <= rsp_ok || timeout_fire;
      if (rsp_ok)            out_flag <= db_out_flag;
      else if (timeout_fire) out_flag <= TIMEOUT_FLAG;
      if (db_out_valid && (inflight == '0)) spurious <= 1'b1;
    end
  end

`ifdef DB_REQ_QUEUE_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer;

  assign timeout_fire = (inflight != '0) && !db_out_valid && (timer == TMR_LAST);

  // Watchdog: counts idle cycles while anything is outstanding, restarts on any answer
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if ((inflight == '0) || db_out_valid || timeout_fire) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  // No watchdog: constant 0 for any legal TIMEOUT_CYC (>= 2)
  assign timeout_fire = (TIMEOUT_CYC < 2);
`endif

endmodule

// File: doc/db_req_queue.md
# db_req_queue

Request buffer between the Ethernet parser and the KVS lookup core, running in `db_clk`. It absorbs bursts of 96-bit lookup keys, issues them to the lookup core with a bounded number of requests in flight, and returns in-order results to the parser. It synthesizes a timeout result when the core stops answering.

## Interface
- `KEY_SIZE`, 96, key width in bits.
- `FLAG_SIZE`, 4, flag width in bits.
- `DEPTH_LOG2`, 4, log2 of the FIFO depth (16 entries).
- `MAX_INFLIGHT`, 4, maximum requests issued but not yet answered (1..15).
- `TIMEOUT_CYC`, 1024, idle cycles with requests in flight before a synthetic result is emitted (≥2).
- `TIMEOUT_FLAG`, 4'hF, flag value carried by a synthetic timeout result.

Ports:
- `clk`  in  1  `db_clk`; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_key`  in  KEY_SIZE  key from the parser.
- `in_flag`  in  FLAG_SIZE  request flag from the parser.
- `in_valid`  in  1  one-cycle request strobe; there is no backpressure.
- `out_valid`  out  1  result strobe to the parser.
- `out_flag`  out  FLAG_SIZE  result flag.
- `db_key`  out  KEY_SIZE  key to the lookup core.
- `db_flag`  out  FLAG_SIZE  flag to the lookup core.
- `db_valid`  out  1  one-cycle issue strobe.
- `db_out_valid`  in  1  core result strobe.
- `db_out_flag`  in  FLAG_SIZE  core result flag.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `drop_cnt`  out  32  number of requests dropped because the FIFO was full.
- `spurious`  out  1  sticky: a core result arrived with nothing in flight.

## Operation
- FIFO of 2^DEPTH_LOG2 entries, each {key, flag}. Pointers are DEPTH_LOG2 bits wide and wrap naturally. `level` is 0..DEPTH.
- Write rule: when `in_valid` is high, the entry is written only if `level` < DEPTH at the start of the cycle. Otherwise it is dropped and `drop_cnt` increments, saturating at 32'hFFFFFFFF. A pop in the same cycle does not make room for the write.
- Issue FSM has two states:
  - IDLE → ISSUE when `level` != 0 and `inflight` < MAX_INFLIGHT.
  - ISSUE drives `db_valid` = 1 for one cycle with the popped entry, increments `inflight`, then returns to IDLE.
  - The maximum issue rate is therefore one request every 2 cycles.
- `inflight` counter:
  - +1 on issue.
  - −1 on `db_out_valid`, or on timeout.
  - Both in the same cycle: value unchanged.
- Results:
  - If `db_out_valid` arrives and `inflight` > 0, it is forwarded as `out_valid`/`out_flag` = `db_out_flag`.
  - If `db_out_valid` arrives and `inflight` = 0, it is not forwarded and `spurious` is set. `spurious` clears only on `rst`.
- Timeout timer:
  - Cleared when `inflight` = 0, and on every `db_out_valid`.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT_CYC−1: emits `out_valid` with `out_flag` = TIMEOUT_FLAG, decrements `inflight`, and restarts from 0.
  - If a real result arrives in the same cycle as the timeout, the real result wins and no synthetic result is emitted.
- Results are in issue order; no tags are used.

## Timing
- Reset values: `out_valid`, `db_valid`, `spurious` = 0; `out_flag`, `db_key`, `db_flag` = 0; `level` = 0; `drop_cnt` = 0. The FSM resets to IDLE; `inflight` and the timer reset to 0.
- Latency with an empty FIFO: `in_valid` at cycle N gives `level` = 1 at N+1 and `db_valid` at N+2.
- Result path: `db_out_valid` at cycle N gives `out_valid` at N+1 (registered).
- Timeout: with `inflight` ≥ 1 and no result since issue cycle I, the synthetic `out_valid` occurs at I+TIMEOUT_CYC+1.
- `rst` asserted mid-operation discards FIFO contents and in-flight accounting on the next edge. Core results arriving after reset are treated as spurious.

## Configuration
- `DB_REQ_QUEUE_TIMEOUT_EN` defined: the timeout timer and synthetic results are present as described above.
- Not defined: no timer is instantiated. `inflight` decrements only on `db_out_valid`, and `out_flag` never carries a synthetic value. All other behaviour is identical.

## Test plan
- Single request: `in_valid` with key 96'h1, flag 4'h1 at cycle 10 → `db_valid` at 12 with the same key and flag. `db_out_flag` 4'h2 returned at 20 → `out_valid` at 21 with `out_flag` 4'h2.
- Overflow: 20 back-to-back `in_valid` with the core silent and MAX_INFLIGHT=4 → 4 issued, FIFO fills to 16, `drop_cnt` = 0 until the FIFO is full, then increments once per extra request. `level` never exceeds 16.
- Inflight cap: the core never answers → exactly 4 `db_valid` pulses. Answering one result → exactly one more issue, 2 cycles later.
- Timeout (macro defined, TIMEOUT_CYC=16): issue at cycle I with no answer → `out_valid` with flag 4'hF at I+17, and `inflight` drops to 0.
- Race: real result and timeout in the same cycle → exactly one `out_valid`, carrying the real flag.
- Spurious and reset: `db_out_valid` with `inflight` = 0 → no `out_valid`, `spurious` = 1. Then `rst` for 1 cycle with 5 entries queued → all outputs return to their reset values and the queued entries are never issued.
